sysid_check_master: RTL and testbench

//  Avalon-MM read master that sits directly upstream of the system ID slave and consumes its readdata.

---
 rtl/sysid_check_master.sv | 201 ++++++++++++++++++++
 tb/tb_sysid_check_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system ID and build timestamp words,
// compares them with the expected values and publishes sticky check status.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h55E5C104,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        check_done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, NEXT, DONE} state_t;

    localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        word_q, word_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        busy_q, busy_d;
    logic        check_done_q, check_done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        pass_q, pass_d;
    logic        timeout_err_q, timeout_err_d;

    logic        launch;
    logic        enter_req;
    logic        expire;
    logic        at_limit;

    assign at_limit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        retry_d       = retry_q;
        cnt_d         = cnt_q;
        auto_d        = 1'b0;
        read_d        = read_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        busy_d        = busy_q;
        check_done_d  = check_done_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        pass_d        = pass_q;
        timeout_err_d = timeout_err_q;
        launch        = 1'b0;
        enter_req     = 1'b0;
        expire        = 1'b0;

        case (state_q)
            IDLE: launch = start || auto_q;
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (!avm_waitrequest) begin
                    state_d = WAIT_DATA;
                    read_d  = 1'b0;
                end else if (at_limit) begin
                    expire = 1'b1;
                end
            end
            WAIT_DATA: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving on the limit cycle still counts as a good response.
                if (avm_readdatavalid) begin
                    state_d = NEXT;
                    if (word_q) begin
                        ts_value_d = avm_readdata;
                        ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    end else begin
                        id_value_d = avm_readdata;
                        id_ok_d    = (avm_readdata == EXPECTED_ID);
                    end
                end else if (at_limit) begin
                    expire = 1'b1;
                end
            end
            NEXT: begin
                if (!word_q) begin
                    word_d    = 1'b1;
                    retry_d   = 8'd0;
                    enter_req = 1'b1;
                end else begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    check_done_d = 1'b1;
                    pass_d       = id_ok_q && (ts_ok_q || !CHECK_TS);
                end
            end
            DONE: launch = start;
            default: state_d = IDLE;
        endcase

        if (expire) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d   = retry_q + 8'd1;
                enter_req = 1'b1;
            end else begin
                state_d       = DONE;
                read_d        = 1'b0;
                busy_d        = 1'b0;
                check_done_d  = 1'b1;
                timeout_err_d = 1'b1;
                pass_d        = 1'b0;
            end
        end

        if (launch) begin
            check_done_d  = 1'b0;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
            pass_d        = 1'b0;
            timeout_err_d = 1'b0;
            word_d        = 1'b0;
            retry_d       = 8'd0;
            busy_d        = 1'b1;
            enter_req     = 1'b1;
        end

        if (enter_req) begin
            state_d = REQ;
            cnt_d   = 8'd0;
            read_d  = 1'b1;
        end

        addr_d = word_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            word_q        <= 1'b0;
            retry_q       <= 8'd0;
            cnt_q         <= 8'd0;
            auto_q        <= AUTO_START;
            read_q        <= 1'b0;
            addr_q        <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
            busy_q        <= 1'b0;
            check_done_q  <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            pass_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            retry_q       <= retry_d;
            cnt_q         <= cnt_d;
            auto_q        <= auto_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
            busy_q        <= busy_d;
            check_done_q  <= check_done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            pass_q        <= pass_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign busy        = busy_q;
    assign check_done  = check_done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign pass        = pass_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: behavioural Avalon slave plus an outcome model
// derived from stall/latency/data settings of each word.
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'hACD51302;
    localparam logic [31:0] EXP_TS = 32'h55E5C104;
    localparam int          TMO    = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address, avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] id_value, ts_value;
    logic        busy, check_done, id_ok, ts_ok, pass, timeout_err;
    logic        d1_avm_address, d1_avm_read;
    logic [31:0] d1_id_value, d1_ts_value;
    logic        d1_busy, d1_check_done, d1_id_ok, d1_ts_ok, d1_pass, d1_timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    int          cfg_stall [2];
    int          cfg_lat   [2];
    bit          cfg_drop  [2];
    logic [31:0] cfg_data  [2];

    int   stall_cnt = 0;
    int   rsp_cnt = 0;
    logic rsp_addr = 1'b0;
    int   iss [2];
    bit   mon_req = 1'b0;
    logic mon_addr = 1'b0;
    int   stab_err = 0;

    logic [31:0] m_id = 32'd0;
    logic [31:0] m_ts = 32'd0;

    always #5 clock = ~clock;

    sysid_check_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .id_value(id_value), .ts_value(ts_value), .busy(busy),
        .check_done(check_done), .id_ok(id_ok), .ts_ok(ts_ok),
        .pass(pass), .timeout_err(timeout_err)
    );

    // Same stimulus, but timestamp mismatches do not fail the check.
    sysid_check_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)
    ) dut_nots (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(d1_avm_address), .avm_read(d1_avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .id_value(d1_id_value), .ts_value(d1_ts_value), .busy(d1_busy),
        .check_done(d1_check_done), .id_ok(d1_id_ok), .ts_ok(d1_ts_ok),
        .pass(d1_pass), .timeout_err(d1_timeout_err)
    );

    // Slave: decides waitrequest/readdatavalid for the coming rising edge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clock);
            if (mon_req && !(avm_read === 1'b1 && avm_address === mon_addr)) stab_err++;
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0 && !cfg_drop[rsp_addr]) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = cfg_data[rsp_addr];
                end
            end
            if (avm_read === 1'b1 && reset_n === 1'b1) begin
                if (stall_cnt < cfg_stall[avm_address]) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    rsp_cnt   = cfg_lat[avm_address];
                    rsp_addr  = avm_address;
                    iss[avm_address]++;
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
            mon_req  = avm_read && avm_waitrequest;
            mon_addr = avm_address;
        end
    end

    task automatic set_cfg(input logic [31:0] d0, input logic [31:0] d1,
                           input int s0, input int l0, input int s1, input int l1,
                           input bit x0, input bit x1);
        cfg_data[0] = d0;  cfg_data[1] = d1;
        cfg_stall[0] = s0; cfg_lat[0] = l0;
        cfg_stall[1] = s1; cfg_lat[1] = l1;
        cfg_drop[0] = x0;  cfg_drop[1] = x1;
    endtask

    // Runs one check (started by reset release or a start pulse) and compares
    // every status output against the expected outcome.
    task automatic run_check(input bit by_reset, input int pulse_at, input string name);
        int n;
        int exp_n;
        int e_iss0, e_iss1;
        bit ok0, ok1, e_idok, e_tsok, e_tmo, e_pass, e_pass1;
        ok0 = !cfg_drop[0] && (cfg_stall[0] + cfg_lat[0] + 1 <= TMO);
        ok1 = !cfg_drop[1] && (cfg_stall[1] + cfg_lat[1] + 1 <= TMO);
        if (by_reset) begin
            m_id = 32'd0;
            m_ts = 32'd0;
        end
        e_idok = 1'b0; e_tsok = 1'b0; e_tmo = 1'b0;
        e_iss1 = 0;
        exp_n  = 1;
        if (!ok0) begin
            e_tmo = 1'b1; exp_n += 3 * TMO; e_iss0 = 3;
        end else begin
            m_id = cfg_data[0]; e_idok = (m_id == EXP_ID);
            exp_n += cfg_stall[0] + cfg_lat[0] + 2; e_iss0 = 1;
            if (!ok1) begin
                e_tmo = 1'b1; exp_n += 3 * TMO; e_iss1 = 3;
            end else begin
                m_ts = cfg_data[1]; e_tsok = (m_ts == EXP_TS);
                exp_n += cfg_stall[1] + cfg_lat[1] + 2; e_iss1 = 1;
            end
        end
        e_pass  = !e_tmo && e_idok && e_tsok;
        e_pass1 = !e_tmo && e_idok;

        iss[0] = 0; iss[1] = 0; stab_err = 0;
        @(negedge clock);
        if (by_reset) begin
            reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
        end else begin
            start = 1'b1;
        end
        n = 0;
        while (n < 400) begin
            @(negedge clock);
            n++;
            start = (n == pulse_at);
            if (n == 1) begin
                tests_run++;
                if (busy !== 1'b1 || check_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s busy_at_launch: busy=%b check_done=%b required 1/0", name, busy, check_done);
                end
            end
            if (check_done === 1'b1) break;
        end
        start = 1'b0;
        tests_run++;
        if (n !== exp_n) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, n, exp_n);
        end
        tests_run++;
        if (id_value !== m_id || ts_value !== m_ts) begin
            tests_failed++;
            $display("FAIL %s values: id=%h ts=%h required id=%h ts=%h", name, id_value, ts_value, m_id, ts_value);
        end
        tests_run++;
        if ({id_ok, ts_ok, pass, timeout_err, busy} !== {e_idok, e_tsok, e_pass, e_tmo, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s status: id_ok/ts_ok/pass/tmo/busy=%b%b%b%b%b required %b%b%b%b0",
                     name, id_ok, ts_ok, pass, timeout_err, busy, e_idok, e_tsok, e_pass, e_tmo);
        end
        tests_run++;
        if (d1_pass !== e_pass1 || d1_check_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s pass_no_ts: got pass=%b done=%b required pass=%b done=1", name, d1_pass, d1_check_done, e_pass1);
        end
        tests_run++;
        if (iss[0] !== e_iss0 || iss[1] !== e_iss1 || stab_err !== 0) begin
            tests_failed++;
            $display("FAIL %s bus: accepts addr0=%0d addr1=%0d unstable=%0d required %0d/%0d/0",
                     name, iss[0], iss[1], stab_err, e_iss0, e_iss1);
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (check_done !== 1'b1 || busy !== 1'b0 || avm_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s stays_done: done=%b busy=%b read=%b required 1/0/0", name, check_done, busy, avm_read);
        end
    endtask

    task automatic test_reset();
        set_cfg(EXP_ID, EXP_TS, 0, 1, 0, 1, 0, 0);
        reset_n = 1'b1;
        start   = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({avm_read, avm_address, busy, check_done, id_ok, ts_ok, pass, timeout_err} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {avm_read, avm_address, busy, check_done, id_ok, ts_ok, pass, timeout_err});
        end
        tests_run++;
        if (id_value !== 32'd0 || ts_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: id=%h ts=%h required 0/0", id_value, ts_value);
        end
    endtask

    task automatic test_auto_start();
        set_cfg(EXP_ID, EXP_TS, 0, 1, 0, 1, 0, 0);
        run_check(1'b1, 0, "auto_start");
    endtask

    task automatic test_bad_id();
        set_cfg(32'hDEADBEEF, EXP_TS, 0, 1, 0, 1, 0, 0);
        run_check(1'b0, 0, "bad_id");
    endtask

    task automatic test_waitrequest();
        set_cfg(EXP_ID, EXP_TS, 5, 1, 5, 1, 0, 0);
        run_check(1'b0, 0, "waitrequest");
    endtask

    task automatic test_timeouts();
        set_cfg(EXP_ID, 32'h12345678, 0, 1, 0, 1, 0, 0);
        run_check(1'b0, 0, "ts_known");
        set_cfg(EXP_ID, EXP_TS, 0, 1, 0, 1, 1, 0);
        run_check(1'b0, 0, "timeout_id");
        set_cfg(EXP_ID, EXP_TS, 1, 2, 0, 1, 0, 1);
        run_check(1'b0, 0, "timeout_ts");
        set_cfg(EXP_ID, EXP_TS, 0, TMO - 1, 0, 1, 0, 0);
        run_check(1'b0, 0, "data_on_limit");
        set_cfg(EXP_ID, EXP_TS, 0, TMO, 0, 1, 0, 0);
        run_check(1'b0, 0, "late_response");
    endtask

    task automatic test_reset_mid(input bit in_wait, input string name);
        bit found;
        set_cfg(EXP_ID, EXP_TS, 0, 1, in_wait ? 0 : 3, in_wait ? 3 : 1, 0, 0);
        @(negedge clock);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (avm_address === 1'b1 && busy === 1'b1 && avm_read === !in_wait) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL %s reach_word1: got found=0 required 1", name);
        end
        #2 reset_n = 1'b0;
        rsp_cnt = 0; stall_cnt = 0; mon_req = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        #1;
        tests_run++;
        if ({avm_read, busy, check_done, id_ok, ts_ok, pass, timeout_err} !== 7'd0 || id_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL %s async_clear: ctrl=%b id=%h required 0000000/0",
                     name, {avm_read, busy, check_done, id_ok, ts_ok, pass, timeout_err}, id_value);
        end
        set_cfg(EXP_ID, EXP_TS, 0, 1, 0, 1, 0, 0);
        run_check(1'b1, 0, name);
    endtask

    task automatic test_start_while_busy();
        set_cfg(EXP_ID, 32'h0BADF00D, 0, 1, 0, 1, 0, 0);
        run_check(1'b0, 3, "start_busy_bad_ts");
        set_cfg(EXP_ID, EXP_TS, 2, 2, 0, 3, 0, 0);
        run_check(1'b0, 5, "start_busy_good");
    endtask

    task automatic test_random();
        logic [31:0] d0, d1;
        for (int k = 0; k < 12; k++) begin
            d0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
            d1 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            set_cfg(d0, d1, $urandom_range(0, 3), $urandom_range(1, 4),
                    $urandom_range(0, 3), $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            run_check(1'b0, $urandom_range(0, 4), "random");
        end
    endtask

    initial begin
        iss[0] = 0; iss[1] = 0;
        test_reset();
        test_auto_start();
        test_bad_id();
        test_waitrequest();
        test_timeouts();
        test_reset_mid(1'b1, "reset_in_wait");
        test_reset_mid(1'b0, "reset_in_req");
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
